muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative radix-2 multiply/divide sequencer for the vc16 execute stage.
- Accepts the decoder's mult/div strobes along with the rs1/rs2 operand values.
- Runs a shift-add or shift-subtract datapath for RV cycles, then returns one result to the writeback mux.
- Holds the pipeline via busy and signals completion with a single-cycle done pulse.

Parameters:
- RV, 32, register/operand width in bits (16 and 32 are supported).
- CW, $clog2(RV)+1, iteration counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request strobe; sampled only in IDLE.
- mult  input  1  operation select: multiply (low RV bits of product).
- div  input  1  operation select: divide.
- sgn  input  1  1 = signed operands (two's complement), 0 = unsigned.
- a  input  RV  rs1 value: multiplicand or dividend.
- b  input  RV  rs2 value: multiplier or divisor.
- kill  input  1  abort the operation in flight (trap or flush).
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse; result and rem are valid in that cycle.
- result  output  RV  product low half, or quotient.
- rem  output  RV  remainder (div only; 0 after mult).

Behaviour:
- States: IDLE, MUL, DIV, FIN. State and all datapath registers reset asynchronously when reset=0.
- Reset values: busy=0, done=0, result=0, rem=0, counter=0.
- IDLE, start=1, mult=1: capture |a| and |b| (magnitudes only when sgn=1), neg=sgn&(a[RV-1]^b[RV-1]), counter=RV, go to MUL. mult takes priority if mult and div are both high.
- IDLE, start=1, div=1, b!=0: capture magnitudes, qneg=sgn&(a[RV-1]^b[RV-1]), rneg=sgn&a[RV-1], counter=RV, go to DIV.
- IDLE, start=1, div=1, b==0: load result=all-ones and rem=a unmodified, go straight to FIN.
- IDLE, start=1, neither mult nor div: ignored; stay in IDLE.
- MUL, one bit per cycle: if multiplier LSB is set, acc+=multiplicand. Shift multiplicand left, shift multiplier right, decrement counter. acc is RV bits, so overflow bits are discarded.
- DIV, restoring, one bit per cycle: shift {rem,quot} left one bit, bringing in the dividend MSB. If partial remainder >= divisor: subtract and set quot LSB=1. Decrement counter.
- MUL/DIV exit: when counter reaches 1, go to FIN on the next edge (exactly RV iteration cycles).
- FIN entry: result and rem get their sign fix-up (negate when neg/qneg/rneg). done=1 for exactly that cycle, then IDLE.
- Latency: start sampled at edge 0 -> done high in cycle RV+1. Divide-by-zero -> done high in cycle 1.
- Signed overflow (-2^(RV-1) / -1): quotient=0x8000..0, rem=0. This falls out of magnitude arithmetic; no special case.
- done and busy are decoded from the state register (glitch-free, no combinational path from inputs).
- start while busy=1: ignored, including during the FIN cycle. The earliest next accept is the cycle after done.
- kill=1 in MUL/DIV: go to IDLE next edge, no done; result and rem keep their previous values.
- kill=1 in FIN: done still pulses that cycle, then IDLE.
- kill=1 in IDLE: no effect, and it overrides a simultaneous start (no accept).
- result and rem hold their values until the next FIN.
- reset asserted mid-operation: immediate return to IDLE with all outputs at reset values.
- Operand inputs are not needed after the start cycle; the upstream stage may change them freely.

Test Plan:
- RV=32, unsigned mult a=7, b=6 -> busy high cycles 1..33, done at cycle 33, result=42, rem=0.
- Signed mult a=-7 (0xFFFFFFF9), b=3 -> result=0xFFFFFFEB; unsigned mult 0xFFFFFFFF*2 -> result=0xFFFFFFFE.
- Unsigned div 100/7 -> result=14, rem=2.
- Signed div -100/7 -> result=0xFFFFFFF2, rem=0xFFFFFFFE.
- Signed 0x80000000 / 0xFFFFFFFF -> result=0x80000000, rem=0.
- Div by zero 5/0 -> done at cycle 1, result=0xFFFFFFFF, rem=5.
- Start div, kill at cycle 10 -> no done, busy=0 at cycle 11, result unchanged. A new start at cycle 12 mult 3*4 -> result=12 at cycle 45.
- Start pulses during busy and during FIN are ignored (single done). Reset=0 at cycle 5 -> busy=0, done=0, result=0 immediately. After reset is released, start completes normally.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Handshake and operand bundle between the vc16 execute stage and the
// iterative multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int RV = 32
);
  logic          start;
  logic          mult;
  logic          div;
  logic          sgn;
  logic [RV-1:0] a;
  logic [RV-1:0] b;
  logic          kill;
  logic          busy;
  logic          done;
  logic [RV-1:0] result;
  logic [RV-1:0] rem;

  modport master (
    output start, mult, div, sgn, a, b, kill,
    input  busy, done, result, rem
  );

  modport slave (
    input  start, mult, div, sgn, a, b, kill,
    output busy, done, result, rem
  );
endinterface

// File: rtl/muldiv_seq.sv
// Radix-2 iterative multiply (low half) / restoring divide sequencer.
// Signed operands are handled as magnitudes with a sign fix-up on the way into FIN.
module muldiv_seq #(
  parameter int RV = 32,
  parameter int CW = $clog2(RV) + 1
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIN} state_t;

  state_t        state_r, state_nx_s;
  logic [CW-1:0] cnt_r;
  logic [RV-1:0] acc_r;     // product accumulator, or partial remainder
  logic [RV-1:0] mcand_r;   // multiplicand, or divisor
  logic [RV-1:0] mplier_r;  // multiplier, or dividend shifting into quotient
  logic          neg_r;
  logic          rneg_r;
  logic [RV-1:0] result_r;
  logic [RV-1:0] rem_r;

  logic          acc_mul_s, acc_div_s;
  logic [RV-1:0] abs_a_s, abs_b_s;
  logic [RV-1:0] mul_acc_s;
  logic [RV:0]   div_shift_s;
  logic          div_ge_s;
  logic [RV-1:0] div_rem_s, div_quot_s;

  function automatic logic [RV-1:0] cond_neg(input logic n, input logic [RV-1:0] v);
    return n ? -v : v;
  endfunction

  assign bus.busy   = (state_r != ST_IDLE);
  assign bus.done   = (state_r == ST_FIN);
  assign bus.result = result_r;
  assign bus.rem    = rem_r;

  // Accept decode, operand magnitudes and one iteration step of each datapath
  always_comb begin
    acc_mul_s   = (state_r == ST_IDLE) && bus.start && !bus.kill && bus.mult;
    acc_div_s   = (state_r == ST_IDLE) && bus.start && !bus.kill && !bus.mult && bus.div;
    abs_a_s     = cond_neg(bus.sgn & bus.a[RV-1], bus.a);
    abs_b_s     = cond_neg(bus.sgn & bus.b[RV-1], bus.b);
    mul_acc_s   = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    div_shift_s = {acc_r, mplier_r[RV-1]};
    div_ge_s    = (div_shift_s >= {1'b0, mcand_r});
    div_rem_s   = div_ge_s ? (div_shift_s[RV-1:0] - mcand_r) : div_shift_s[RV-1:0];
    div_quot_s  = {mplier_r[RV-2:0], div_ge_s};
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; kill overrides a same-cycle start, FIN always completes
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (acc_mul_s) begin
          state_nx_s = ST_MUL;
        end else if (acc_div_s) begin
          state_nx_s = (bus.b == {RV{1'b0}}) ? ST_FIN : ST_DIV;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (bus.kill) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_r == CW'(1)) begin
          state_nx_s = ST_FIN;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_FIN:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and signed result on the final step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {RV{1'b0}};
      mcand_r  <= {RV{1'b0}};
      mplier_r <= {RV{1'b0}};
      neg_r    <= 1'b0;
      rneg_r   <= 1'b0;
      result_r <= {RV{1'b0}};
      rem_r    <= {RV{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (acc_mul_s) begin
            mcand_r  <= abs_a_s;
            mplier_r <= abs_b_s;
            acc_r    <= {RV{1'b0}};
            cnt_r    <= CW'(RV);
            neg_r    <= bus.sgn & (bus.a[RV-1] ^ bus.b[RV-1]);
            rneg_r   <= 1'b0;
          end else if (acc_div_s && (bus.b == {RV{1'b0}})) begin
            result_r <= {RV{1'b1}};
            rem_r    <= bus.a;
          end else if (acc_div_s) begin
            mcand_r  <= abs_b_s;
            mplier_r <= abs_a_s;
            acc_r    <= {RV{1'b0}};
            cnt_r    <= CW'(RV);
            neg_r    <= bus.sgn & (bus.a[RV-1] ^ bus.b[RV-1]);
            rneg_r   <= bus.sgn & bus.a[RV-1];
          end
        end
        ST_MUL: begin
          if (!bus.kill) begin
            acc_r    <= mul_acc_s;
            mcand_r  <= {mcand_r[RV-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[RV-1:1]};
            cnt_r    <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
              result_r <= cond_neg(neg_r, mul_acc_s);
              rem_r    <= {RV{1'b0}};
            end
          end
        end
        ST_DIV: begin
          if (!bus.kill) begin
            acc_r    <= div_rem_s;
            mplier_r <= div_quot_s;
            cnt_r    <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
              result_r <= cond_neg(neg_r, div_quot_s);
              rem_r    <= cond_neg(rneg_r, div_rem_s);
            end
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule
